lif_spike_network: RTL and testbench
====================================

// Module: lif_spike_network
// PURPOSE
//  Parametrised leaky-integrate-and-fire network: N_IN input LIF neurons, one weighted synapse
//  stage, one output LIF neuron. Adds leak, refractory period, saturating arithmetic, enable
//  and an output spike counter. Sits between the external current inputs and spike readout.
// PARAMETERS
//  N_IN        3                       number of input neurons
//  W_IN        4                       width of each external input current
//  W_MEM       8                       membrane potential width (all neurons)
//  W_WT        4                       synaptic weight width
//  W_SYN       6                       synaptic current register width
//  W_CNT       8                       output spike counter width
//  THRESH      20                      firing threshold (W_MEM bits, compare >=)
//  LEAK_SHIFT  3                       leak = mem >> LEAK_SHIFT per enabled cycle
//  REFRAC      2                       refractory cycles after a spike (0 = none)
//  WEIGHTS     {4'd3,4'd4,4'd5}        packed N_IN*W_WT weights; slice i = weight of input i
// PORTS
//  clk        in   1            clock
//  reset      in   1            asynchronous, active-low reset
//  en         in   1            advance enable; low = freeze all state
//  ext_in     in   N_IN*W_IN    packed currents; slice i drives input neuron i
//  spike_in   out  N_IN         registered spikes of input neurons
//  syn_cur    out  W_SYN        registered synaptic current into output neuron
//  out_mem    out  W_MEM        output neuron membrane potential
//  spike_out  out  1            registered output neuron spike
//  spike_cnt  out  W_CNT        count of output spikes, saturating
// BEHAVIOUR
//  - Reset: every output, all membranes, refractory counters and weights-in-use at reset value;
//    all outputs 0 (spike_in, syn_cur, out_mem, spike_out, spike_cnt). Reset is async, mid-op OK.
//  - Neuron update on enabled edge: if refr>0: mem<=0, spike<=0, refr<=refr-1.
//    Else nxt = sat(mem - (mem>>LEAK_SHIFT) + cur) clamped to 2^W_MEM-1;
//    nxt>=THRESH: spike<=1, mem<=0, refr<=REFRAC; else spike<=0, mem<=nxt.
//  - Spikes are one-cycle pulses per firing; cur zero-extended to W_MEM.
//  - Synapse: syn_cur <= sat(sum over i of spike_in[i] ? w[i] : 0) to 2^W_SYN-1;
//    syn_cur returns to 0 on any enabled edge with no input spike (no hold).
//  - Latency: spike_in at edge k -> syn_cur at k+1 -> output neuron integrates at k+2
//    (spike_out earliest at k+2).
//  - spike_cnt increments on every edge where spike_out is set; holds at 2^W_CNT-1.
//  - en=0: spike_in, spike_out forced 0 on next edge; mem, refr, syn_cur, spike_cnt held.
//  - Simultaneous spikes from all inputs sum in one cycle; threshold exactly hit fires.
// CONFIGURATION
//  LIF_WEIGHT_LOAD_EN defined: extra ports wt_we(in,1), wt_addr(in,clog2(N_IN)),
//    wt_data(in,W_WT); weight regs reset to WEIGHTS, wt_we writes w[wt_addr] at edge,
//    new value used from next edge; wt_addr>=N_IN ignored; writes ignore en.
//  Undefined: no extra ports, weights are constant WEIGHTS.
// STRUCTURE
//  - lif_pkg: default widths, THRESH/LEAK_SHIFT/REFRAC defaults, sat_add function.
//  - Sub-module lif_core: one neuron (mem, refr, spike, en); instanced N_IN+1 times.
//  - Top: generate loop of lif_core, synapse adder/saturation, weight regs, counter.
// TESTING
//  1 Assert reset mid-run with ext_in=all 15 -> all outputs 0 immediately, restart clean.
//  2 ext_in=all 15 from reset release -> spike_in=3'b111 at edge 2, 6, 10 (period 4);
//    syn_cur=12 at edges 3, 7; out_mem 12,11,10,9 at edges 4-7; spike_out at edge 8,
//    out_mem=0, spike_cnt=1.
//  3 ext_in slice0=15 only -> out_mem stays below THRESH, spike_in[0] period 4, syn_cur
//    alternates 5/0; REFRAC=0 override -> spike_in[0] period 2.
//  4 W_SYN=4, WEIGHTS all 15, all inputs spike -> syn_cur saturates at 15, no wrap.
//  5 en=0 for 5 cycles mid-integration -> mem/syn_cur/spike_cnt frozen, spikes 0; resume exact.
//  6 LIF_WEIGHT_LOAD_EN: write w[0]=0 -> syn_cur=7 on next all-spike; wt_addr=3 write ignored.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared defaults and helpers for the leaky-integrate-and-fire spike network.
// Contents:
//   LIF_* localparams  default widths, threshold, leak shift and refractory length
//   sat_t / SAT_W      wide unsigned working type for saturating arithmetic
//   sat_add            unsigned add clamped to a caller-supplied ceiling
package lif_pkg;

    localparam int LIF_N_IN       = 3;
    localparam int LIF_W_IN       = 4;
    localparam int LIF_W_MEM      = 8;
    localparam int LIF_W_WT       = 4;
    localparam int LIF_W_SYN      = 6;
    localparam int LIF_W_CNT      = 8;
    localparam int LIF_THRESH     = 20;
    localparam int LIF_LEAK_SHIFT = 3;
    localparam int LIF_REFRAC     = 2;

    // Working width for saturating sums; every field in the design is narrower.
    localparam int SAT_W = 16;
    typedef logic [SAT_W-1:0] sat_t;

    // a + b, clamped to max_v. A one-bit-wider sum means a carry can never wrap.
    function automatic sat_t sat_add(input sat_t a, input sat_t b, input sat_t max_v);
        logic [SAT_W:0] sum_v;
        sum_v = {1'b0, a} + {1'b0, b};
        if (sum_v > {1'b0, max_v}) begin
            return max_v;
        end else begin
            return sum_v[SAT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/lif_core.sv
// One leaky-integrate-and-fire neuron.
// Ports:
//   clk, reset  clock; asynchronous active-low reset
//   en          advance enable; low holds mem/refractory state and drops spike
//   cur         input current, zero-extended to the membrane width
//   mem         registered membrane potential
//   spike       registered one-cycle spike pulse
//   fire        combinational: this edge will fire (used to count spikes on the same edge)
module lif_core
    import lif_pkg::*;
#(
    parameter int W_CUR      = LIF_W_IN,
    parameter int W_MEM      = LIF_W_MEM,
    parameter int THRESH     = LIF_THRESH,
    parameter int LEAK_SHIFT = LIF_LEAK_SHIFT,
    parameter int REFRAC     = LIF_REFRAC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [W_CUR-1:0] cur,
    output logic [W_MEM-1:0] mem,
    output logic             spike,
    output logic             fire
);

    localparam int   W_REF   = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam sat_t MEM_MAX = sat_t'({W_MEM{1'b1}});

    logic [W_MEM-1:0] mem_r;
    logic [W_REF-1:0] refr_r;
    logic             spike_r;
    logic [W_MEM-1:0] leaked_s;
    logic [W_MEM-1:0] nxt_s;
    sat_t             nxt_wide_s;
    logic             nxt_unused_s;

    // Leak, integrate with saturation, and decide whether this edge fires.
    always_comb begin
        leaked_s   = mem_r - (mem_r >> LEAK_SHIFT);
        nxt_wide_s = sat_add(sat_t'(leaked_s), sat_t'(cur), MEM_MAX);
        nxt_s      = nxt_wide_s[W_MEM-1:0];
        fire       = en && (refr_r == {W_REF{1'b0}}) && (nxt_s >= W_MEM'(THRESH));
    end

    // Bits above the membrane width are always zero after clamping.
    assign nxt_unused_s = ^nxt_wide_s[SAT_W-1:W_MEM];

    // Membrane / refractory / spike state; disabled edges hold state but drop the spike.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_r   <= {W_MEM{1'b0}};
            refr_r  <= {W_REF{1'b0}};
            spike_r <= 1'b0;
        end else if (en) begin
            if (refr_r != {W_REF{1'b0}}) begin
                mem_r   <= {W_MEM{1'b0}};
                spike_r <= 1'b0;
                refr_r  <= refr_r - W_REF'(1);
            end else if (fire) begin
                mem_r   <= {W_MEM{1'b0}};
                spike_r <= 1'b1;
                refr_r  <= W_REF'(REFRAC);
            end else begin
                mem_r   <= nxt_s;
                spike_r <= 1'b0;
            end
        end else begin
            spike_r <= 1'b0;
        end
    end

    assign mem   = mem_r;
    assign spike = spike_r;

endmodule

// File: rtl/lif_spike_network.sv
// N_IN input LIF neurons -> weighted saturating synapse -> one output LIF neuron,
// plus a saturating count of output spikes.
// Ports:
//   clk, reset  clock; asynchronous active-low reset
//   en          advance enable; low freezes state and forces spikes to 0
//   ext_in      packed input currents, slice i drives input neuron i
//   spike_in    registered input-neuron spikes
//   syn_cur     registered synaptic current into the output neuron
//   out_mem     output neuron membrane potential
//   spike_out   registered output spike
//   spike_cnt   saturating output spike count
// Optional build macro LIF_WEIGHT_LOAD_EN adds wt_we / wt_addr / wt_data for run-time
// weight writes (independent of en; out-of-range addresses ignored). Without it the
// weights are the constant WEIGHTS parameter.
module lif_spike_network
    import lif_pkg::*;
#(
    parameter int N_IN       = LIF_N_IN,
    parameter int W_IN       = LIF_W_IN,
    parameter int W_MEM      = LIF_W_MEM,
    parameter int W_WT       = LIF_W_WT,
    parameter int W_SYN      = LIF_W_SYN,
    parameter int W_CNT      = LIF_W_CNT,
    parameter int THRESH     = LIF_THRESH,
    parameter int LEAK_SHIFT = LIF_LEAK_SHIFT,
    parameter int REFRAC     = LIF_REFRAC,
    parameter logic [N_IN*W_WT-1:0] WEIGHTS = {4'd3, 4'd4, 4'd5},
    localparam int W_ADDR    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [N_IN*W_IN-1:0] ext_in,
`ifdef LIF_WEIGHT_LOAD_EN
    input  logic                 wt_we,
    input  logic [W_ADDR-1:0]    wt_addr,
    input  logic [W_WT-1:0]      wt_data,
`endif
    output logic [N_IN-1:0]      spike_in,
    output logic [W_SYN-1:0]     syn_cur,
    output logic [W_MEM-1:0]     out_mem,
    output logic                 spike_out,
    output logic [W_CNT-1:0]     spike_cnt
);

    localparam sat_t SYN_MAX = sat_t'({W_SYN{1'b1}});

    logic [W_WT-1:0]  wt_s [N_IN];
    logic [W_MEM-1:0] in_mem_unused_s [N_IN];
    logic [N_IN-1:0]  in_fire_unused_s;
    logic             out_fire_s;
    sat_t             syn_sum_s;
    logic             syn_unused_s;
    logic [W_SYN-1:0] syn_cur_r;
    logic [W_CNT-1:0] spike_cnt_r;

`ifdef LIF_WEIGHT_LOAD_EN
    logic [W_WT-1:0] wt_r [N_IN];

    // Loadable weights: reset to WEIGHTS, written regardless of en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_IN; i++) begin
                wt_r[i] <= WEIGHTS[i*W_WT +: W_WT];
            end
        end else if (wt_we && (32'(wt_addr) < N_IN)) begin
            wt_r[wt_addr] <= wt_data;
        end
    end

    assign wt_s = wt_r;
`else
    for (genvar g = 0; g < N_IN; g++) begin : g_wt
        assign wt_s[g] = WEIGHTS[g*W_WT +: W_WT];
    end
`endif

    for (genvar g = 0; g < N_IN; g++) begin : g_in
        lif_core #(
            .W_CUR(W_IN), .W_MEM(W_MEM), .THRESH(THRESH),
            .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC)
        ) u_in (
            .clk(clk), .reset(reset), .en(en),
            .cur(ext_in[g*W_IN +: W_IN]),
            .mem(in_mem_unused_s[g]),
            .spike(spike_in[g]),
            .fire(in_fire_unused_s[g])
        );
    end

    // Saturating sum of the weights of every input neuron that spiked last edge.
    always_comb begin
        syn_sum_s = sat_t'(0);
        for (int i = 0; i < N_IN; i++) begin
            if (spike_in[i]) begin
                syn_sum_s = sat_add(syn_sum_s, sat_t'(wt_s[i]), SYN_MAX);
            end else begin
                syn_sum_s = syn_sum_s;
            end
        end
    end

    assign syn_unused_s = ^syn_sum_s[SAT_W-1:W_SYN];

    // Synaptic current register; no hold across enabled edges, frozen when disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syn_cur_r <= {W_SYN{1'b0}};
        end else if (en) begin
            syn_cur_r <= syn_sum_s[W_SYN-1:0];
        end
    end

    lif_core #(
        .W_CUR(W_SYN), .W_MEM(W_MEM), .THRESH(THRESH),
        .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC)
    ) u_out (
        .clk(clk), .reset(reset), .en(en),
        .cur(syn_cur_r),
        .mem(out_mem),
        .spike(spike_out),
        .fire(out_fire_s)
    );

    // Count output spikes on the edge they are raised, sticking at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spike_cnt_r <= {W_CNT{1'b0}};
        end else if (out_fire_s && (spike_cnt_r != {W_CNT{1'b1}})) begin
            spike_cnt_r <= spike_cnt_r + W_CNT'(1);
        end
    end

    assign syn_cur   = syn_cur_r;
    assign spike_cnt = spike_cnt_r;

endmodule

// File: tb/tb_lif_spike_network.sv
// Directed self-checking bench for lif_spike_network. Three instances share the
// stimulus: the default network, a REFRAC=0 variant and a narrow-synapse
// (W_SYN=4, all weights 15) variant for saturation.
`timescale 1ns/1ps
module tb_lif_spike_network;

    logic        clk;
    logic        reset;
    logic        en;
    logic [11:0] ext_in;
`ifdef LIF_WEIGHT_LOAD_EN
    logic        wt_we;
    logic [1:0]  wt_addr;
    logic [3:0]  wt_data;
`endif

    logic [2:0] spike_in,   r0_spike_in,   st_spike_in;
    logic [5:0] syn_cur,    r0_syn_cur;
    logic [3:0] st_syn_cur;
    logic [7:0] out_mem,    r0_out_mem,    st_out_mem;
    logic       spike_out,  r0_spike_out,  st_spike_out;
    logic [7:0] spike_cnt,  r0_spike_cnt,  st_spike_cnt;

    int checks;
    int failures;

    lif_spike_network dut (
        .clk(clk), .reset(reset), .en(en), .ext_in(ext_in),
`ifdef LIF_WEIGHT_LOAD_EN
        .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
`endif
        .spike_in(spike_in), .syn_cur(syn_cur), .out_mem(out_mem),
        .spike_out(spike_out), .spike_cnt(spike_cnt)
    );

    lif_spike_network #(.REFRAC(0)) dut_r0 (
        .clk(clk), .reset(reset), .en(en), .ext_in(ext_in),
`ifdef LIF_WEIGHT_LOAD_EN
        .wt_we(1'b0), .wt_addr(2'd0), .wt_data(4'd0),
`endif
        .spike_in(r0_spike_in), .syn_cur(r0_syn_cur), .out_mem(r0_out_mem),
        .spike_out(r0_spike_out), .spike_cnt(r0_spike_cnt)
    );

    lif_spike_network #(.W_SYN(4), .WEIGHTS(12'hFFF)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .ext_in(ext_in),
`ifdef LIF_WEIGHT_LOAD_EN
        .wt_we(1'b0), .wt_addr(2'd0), .wt_data(4'd0),
`endif
        .spike_in(st_spike_in), .syn_cur(st_syn_cur), .out_mem(st_out_mem),
        .spike_out(st_spike_out), .spike_cnt(st_spike_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset released 1ns after an edge, so the next posedge is edge 1.
    task automatic do_reset();
        en     = 1'b1;
        reset  = 1'b0;
`ifdef LIF_WEIGHT_LOAD_EN
        wt_we   = 1'b0;
        wt_addr = 2'd0;
        wt_data = 4'd0;
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        ext_in = 12'h000;
        do_reset();
        checks++;
        if ({spike_in, syn_cur, out_mem, spike_out, spike_cnt} !== 26'd0) begin
            failures++;
            $display("FAIL reset_state got %b want 0", {spike_in, syn_cur, out_mem, spike_out, spike_cnt});
        end
        ext_in = 12'hFFF;
        repeat (10) tick();
        checks++;
        if (spike_in !== 3'b111 || spike_cnt !== 8'd1) begin
            failures++;
            $display("FAIL pre_reset spike_in=%b cnt=%0d want 111/1", spike_in, spike_cnt);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({spike_in, syn_cur, out_mem, spike_out, spike_cnt} !== 26'd0) begin
            failures++;
            $display("FAIL async_reset got %b want 0", {spike_in, syn_cur, out_mem, spike_out, spike_cnt});
        end
        reset = 1'b1;
        tick();
        checks++;
        if (spike_in !== 3'b000 || out_mem !== 8'd0) begin
            failures++;
            $display("FAIL restart_e1 spike_in=%b out_mem=%0d want 000/0", spike_in, out_mem);
        end
        tick();
        checks++;
        if (spike_in !== 3'b111) begin
            failures++;
            $display("FAIL restart_e2 spike_in=%b want 111", spike_in);
        end
    endtask

    task automatic test_integrate();
        logic [2:0] e_si;
        logic [5:0] e_syn;
        logic [7:0] e_mem;
        logic [7:0] e_cnt;
        ext_in = 12'hFFF;
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            tick();
            e_si  = (e == 2 || e == 6 || e == 10) ? 3'b111 : 3'b000;
            e_syn = (e == 3 || e == 7) ? 6'd12 : 6'd0;
            case (e)
                4:       e_mem = 8'd12;
                5:       e_mem = 8'd11;
                6:       e_mem = 8'd10;
                7:       e_mem = 8'd9;
                default: e_mem = 8'd0;
            endcase
            e_cnt = (e >= 8) ? 8'd1 : 8'd0;
            checks++;
            if (spike_in !== e_si || syn_cur !== e_syn || out_mem !== e_mem ||
                spike_out !== (e == 8) || spike_cnt !== e_cnt) begin
                failures++;
                $display("FAIL integrate_e%0d got si=%b syn=%0d mem=%0d so=%b cnt=%0d want si=%b syn=%0d mem=%0d so=%b cnt=%0d",
                         e, spike_in, syn_cur, out_mem, spike_out, spike_cnt,
                         e_si, e_syn, e_mem, (e == 8), e_cnt);
            end
        end
    endtask

    task automatic test_single_input();
        logic [2:0] e_si;
        logic [5:0] e_syn;
        logic [2:0] e_r0;
        ext_in = 12'h00F;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            tick();
            e_si  = ((e % 4) == 2) ? 3'b001 : 3'b000;
            e_syn = (e >= 3 && (e % 4) == 3) ? 6'd5 : 6'd0;
            e_r0  = ((e % 2) == 0) ? 3'b001 : 3'b000;
            checks++;
            if (spike_in !== e_si || syn_cur !== e_syn || out_mem >= 8'd20 || spike_out !== 1'b0) begin
                failures++;
                $display("FAIL single_e%0d got si=%b syn=%0d mem=%0d so=%b want si=%b syn=%0d mem<20 so=0",
                         e, spike_in, syn_cur, out_mem, spike_out, e_si, e_syn);
            end
            checks++;
            if (r0_spike_in !== e_r0) begin
                failures++;
                $display("FAIL refrac0_e%0d got si=%b want %b", e, r0_spike_in, e_r0);
            end
        end
    endtask

    task automatic test_saturate();
        ext_in = 12'hFFF;
        do_reset();
        repeat (3) tick();
        checks++;
        if (st_syn_cur !== 4'd15) begin
            failures++;
            $display("FAIL syn_saturate got %0d want 15", st_syn_cur);
        end
    endtask

    task automatic test_enable();
        ext_in = 12'hFFF;
        do_reset();
        repeat (7) tick();
        checks++;
        if (syn_cur !== 6'd12 || out_mem !== 8'd9) begin
            failures++;
            $display("FAIL pre_freeze syn=%0d mem=%0d want 12/9", syn_cur, out_mem);
        end
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (spike_in !== 3'b000 || syn_cur !== 6'd12 || out_mem !== 8'd9 ||
                spike_out !== 1'b0 || spike_cnt !== 8'd0) begin
                failures++;
                $display("FAIL freeze_c%0d got si=%b syn=%0d mem=%0d so=%b cnt=%0d want 000/12/9/0/0",
                         c, spike_in, syn_cur, out_mem, spike_out, spike_cnt);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (spike_out !== 1'b1 || out_mem !== 8'd0 || spike_cnt !== 8'd1 || syn_cur !== 6'd0) begin
            failures++;
            $display("FAIL resume_e8 got so=%b mem=%0d cnt=%0d syn=%0d want 1/0/1/0",
                     spike_out, out_mem, spike_cnt, syn_cur);
        end
        en = 1'b0;
        tick();
        checks++;
        if (spike_out !== 1'b0 || spike_cnt !== 8'd1) begin
            failures++;
            $display("FAIL freeze_out_spike got so=%b cnt=%0d want 0/1", spike_out, spike_cnt);
        end
        en = 1'b1;
        tick();
        checks++;
        if (spike_in !== 3'b000) begin
            failures++;
            $display("FAIL resume_e9 got si=%b want 000", spike_in);
        end
        en = 1'b0;
        tick();
        checks++;
        if (spike_in !== 3'b000) begin
            failures++;
            $display("FAIL freeze_in_spike got si=%b want 000", spike_in);
        end
        en = 1'b1;
        tick();
        checks++;
        if (spike_in !== 3'b111) begin
            failures++;
            $display("FAIL resume_e10 got si=%b want 111", spike_in);
        end
    endtask

`ifdef LIF_WEIGHT_LOAD_EN
    task automatic test_weight_load();
        ext_in = 12'hFFF;
        do_reset();
        en      = 1'b0;
        wt_we   = 1'b1;
        wt_addr = 2'd0;
        wt_data = 4'd0;
        tick();
        wt_addr = 2'd3;
        tick();
        wt_we = 1'b0;
        en    = 1'b1;
        repeat (3) tick();
        checks++;
        if (syn_cur !== 6'd7) begin
            failures++;
            $display("FAIL weight_load got syn=%0d want 7", syn_cur);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        en       = 1'b1;
        ext_in   = 12'h000;
        test_reset();
        test_integrate();
        test_single_input();
        test_saturate();
        test_enable();
`ifdef LIF_WEIGHT_LOAD_EN
        test_weight_load();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
